// File: rtl/alu_shift_datapath_pkg.sv
// alu_shift_datapath_pkg: ALU/shift encodings and FSM state type shared by the datapath
package alu_shift_datapath_pkg;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_PASSM = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;
  localparam logic [1:0] SH_NONE  = 2'b00;
  localparam logic [1:0] SH_SLL   = 2'b01;
  localparam logic [1:0] SH_SRL   = 2'b10;
  localparam logic [1:0] SH_SRA   = 2'b11;
  typedef enum logic [1:0] {IDLE, ALU, SHIFT, WRITE} state_t;
endpackage

// File: rtl/alu_shift_datapath_alu_unit.sv
// alu_unit: combinational ALU; carry is carry-out for add, borrow for subtract, else 0
module alu_unit
  import alu_shift_datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] x,
  output logic             carry
);
  logic [WIDTH:0] w_sum, w_dif;
  assign w_sum = {1'b0, a} + {1'b0, m};
  assign w_dif = {1'b0, a} - {1'b0, m};
  always_comb begin
    x = a;
    carry = 1'b0;
    case (alu_op)
      OP_ADD:   {carry, x} = w_sum;
      OP_SUB:   {carry, x} = w_dif;
      OP_AND:   x = a & m;
      OP_OR:    x = a | m;
      OP_XOR:   x = a ^ m;
      OP_NOT:   x = ~a;
      OP_PASSM: x = m;
      default:  x = a;
    endcase
  end
endmodule

// File: rtl/alu_shift_datapath.sv
// alu_shift_datapath: multi-cycle ALU -> serial shifter -> Q/R write, one command at a time
module alu_shift_datapath
  import alu_shift_datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       alu_op,
  input  logic             mux_sel,
  input  logic [1:0]       shift_op,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             q_en,
  input  logic             r_en,
  output logic [WIDTH-1:0] Q,
  output logic             carry,
  output logic             done
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_x, r_r, r_q, w_m, w_x, w_sh;
  logic [2:0]       r_op;
  logic [1:0]       r_sop;
  logic [SHW-1:0]   r_amt, r_cnt;
  logic             r_sel, r_qen, r_ren, r_c, r_carry, r_done, w_c, w_acc;
  assign cmd_ready = r_state == IDLE;
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_m       = r_sel ? r_r : r_b;
  assign Q         = r_q;
  assign carry     = r_carry;
  assign done      = r_done;
  alu_unit #(.WIDTH(WIDTH)) u_alu (.a(r_a), .m(w_m), .alu_op(r_op), .x(w_x), .carry(w_c));
  assign w_sh = r_sop == SH_SLL ? {r_x[WIDTH-2:0], 1'b0}
              : r_sop == SH_SRL ? {1'b0, r_x[WIDTH-1:1]}
              : {r_x[WIDTH-1], r_x[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_acc ? ALU : IDLE;
      ALU:     w_next = (r_sop != SH_NONE && r_amt != '0) ? SHIFT : WRITE;
      SHIFT:   w_next = r_cnt > SHW'(1) ? SHIFT : WRITE;
      default: w_next = IDLE;
    endcase
  end
  // R written by a command is visible to the next one since its ALU cycle follows the WRITE edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_sel   <= 1'b0;
      r_sop   <= '0;
      r_amt   <= '0;
      r_qen   <= 1'b0;
      r_ren   <= 1'b0;
      r_x     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= alu_op;
        r_sel <= mux_sel;
        r_sop <= shift_op;
        r_amt <= shift_amt;
        r_qen <= q_en;
        r_ren <= r_en;
      end
      if (r_state == ALU) begin
        r_x   <= w_x;
        r_c   <= w_c;
        r_cnt <= r_amt;
      end
      if (r_state == SHIFT) begin
        r_x   <= w_sh;
        r_cnt <= r_cnt - SHW'(1);
      end
      if (r_state == WRITE) begin
        if (r_qen) r_q <= r_x;
        if (r_ren) r_r <= r_x;
        r_carry <= r_c;
      end
      r_done <= r_state == WRITE;
    end
endmodule

// File: tb/tb_alu_shift_datapath.sv
// tb_alu_shift_datapath: directed vectors with hand-computed results for the WIDTH=8 datapath
module tb_alu_shift_datapath;
  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, mux_sel, q_en, r_en, carry, done;
  logic [7:0] A, B, Q;
  logic [2:0] alu_op, shift_amt;
  logic [1:0] shift_op;
  int         n_checks = 0;
  int         n_fail = 0;

  alu_shift_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .A(A), .B(B), .alu_op(alu_op), .mux_sel(mux_sel), .shift_op(shift_op),
    .shift_amt(shift_amt), .q_en(q_en), .r_en(r_en), .Q(Q), .carry(carry), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic sel, input logic [1:0] sop, input logic [2:0] amt,
                       input logic qe, input logic re);
    A = a; B = b; alu_op = op; mux_sel = sel; shift_op = sop; shift_amt = amt;
    q_en = qe; r_en = re; cmd_valid = 1'b1;
  endtask

  // inverting every field after accept exposes any command bit that is not captured
  task automatic scramble();
    A = ~A; B = ~B; alu_op = ~alu_op; mux_sel = ~mux_sel; shift_op = ~shift_op;
    shift_amt = ~shift_amt; q_en = ~q_en; r_en = ~r_en;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int e = 0;
    while (!done && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    check({tag, "_lat"}, e, lat);
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input logic sel, input logic [1:0] sop,
                     input logic [2:0] amt, input logic qe, input logic re, input int lat);
    @(negedge clk);
    check({tag, "_rdy"}, cmd_ready, 1);
    drive(a, b, op, sel, sop, amt, qe, re);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble();
    wait_done(tag, lat);
  endtask

  initial begin
    int e, early, seen;
    rst_n = 1'b1; cmd_valid = 1'b0;
    A = '0; B = '0; alu_op = '0; mux_sel = 1'b0; shift_op = '0; shift_amt = '0;
    q_en = 1'b0; r_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_q", Q, 8'h00);
    check("rst_carry", carry, 0);
    check("rst_done", done, 0);
    check("rst_rdy", cmd_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;

    run("add", 8'h35, 8'h12, 3'b000, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("add_q", Q, 8'h47);
    check("add_carry", carry, 0);
    @(posedge clk); #1;
    check("add_done_pulse", done, 0);

    run("r_hold", 8'h35, 8'h00, 3'b100, 1'b1, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("r_hold_q", Q, 8'h35);

    run("fb1", 8'hF0, 8'h20, 3'b000, 1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 2);
    check("fb1_q", Q, 8'h35);
    check("fb1_carry", carry, 1);
    run("fb2", 8'h05, 8'hFF, 3'b001, 1'b1, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("fb2_q", Q, 8'hF5);
    check("fb2_carry", carry, 1);

    run("wrap", 8'hFF, 8'h01, 3'b000, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("wrap_q", Q, 8'h00);
    check("wrap_carry", carry, 1);
    run("and", 8'h3C, 8'h0F, 3'b010, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("and_q", Q, 8'h0C);
    check("and_carry", carry, 0);
    run("not", 8'h3C, 8'h00, 3'b101, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("not_q", Q, 8'hC3);

    run("sll", 8'h81, 8'h00, 3'b111, 1'b0, 2'b01, 3'd3, 1'b1, 1'b0, 5);
    check("sll_q", Q, 8'h08);
    run("sra", 8'h81, 8'h00, 3'b111, 1'b0, 2'b11, 3'd7, 1'b1, 1'b0, 9);
    check("sra_q", Q, 8'hFF);
    run("srl", 8'h81, 8'h00, 3'b111, 1'b0, 2'b10, 3'd7, 1'b1, 1'b0, 9);
    check("srl_q", Q, 8'h01);
    run("byp_op", 8'h81, 8'h00, 3'b111, 1'b0, 2'b00, 3'd5, 1'b1, 1'b0, 2);
    check("byp_op_q", Q, 8'h81);
    run("byp_amt", 8'h3C, 8'h00, 3'b111, 1'b0, 2'b01, 3'd0, 1'b1, 1'b0, 2);
    check("byp_amt_q", Q, 8'h3C);

    @(negedge clk);
    drive(8'h81, 8'h00, 3'b111, 1'b0, 2'b10, 3'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(8'h3C, 8'h0F, 3'b010, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0);
    e = 0;
    early = 0;
    while (!done && e < 40) begin
      if (cmd_ready) early++;
      @(posedge clk); #1;
      e++;
    end
    check("busy_lat", e, 9);
    check("busy_early_rdy", early, 0);
    check("busy_q1", Q, 8'h01);
    check("busy_done_rdy", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble();
    wait_done("busy2", 2);
    check("busy_q2", Q, 8'h0C);

    run("borrow", 8'h00, 8'h01, 3'b001, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("borrow_q", Q, 8'hFF);
    check("borrow_carry", carry, 1);

    @(negedge clk);
    drive(8'h81, 8'h00, 3'b111, 1'b0, 2'b01, 3'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_q", Q, 8'h00);
    check("abort_carry", carry, 0);
    check("abort_done", done, 0);
    check("abort_rdy", cmd_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_q_hold", Q, 8'h00);
    run("r_post", 8'h00, 8'hAA, 3'b110, 1'b1, 2'b00, 3'd0, 1'b1, 1'b0, 2);
    check("r_post_q", Q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
